mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, multiply request, sampled only in IDLE.
REQ-004 SHALL have port op_a, input, 16, multiplicand, captured with an accepted start.
REQ-005 SHALL have port op_b, input, 16, multiplier, captured with an accepted start.
REQ-006 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-007 SHALL have port out_valid, output, 1, product valid, high only in DONE.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts the product.
REQ-009 SHALL have port product, output, 16, low 16 bits of op_a*op_b.
REQ-010 SHALL have port alu_own, output, 1, high only in RUN; the datapath uses it to grant the shared ALU to this block.
REQ-011 SHALL have port alu_opcode, output, 5, 5'b11011 in RUN, else 0.
REQ-012 SHALL have port alu_funct, output, 2, 2'b00 (ADD) in every state.
REQ-013 SHALL have port alu_rs, output, 16, accumulator in RUN, else 0.
REQ-014 SHALL have port alu_rt, output, 16, shifted multiplicand in RUN, else 0.
REQ-015 SHALL have port alu_res, input, 16, combinational ALU result, alu_rs+alu_rt.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; encoding is free.
REQ-017 IDLE with start=1 SHALL load acc=0, mcand=op_a, mplr=op_b, cnt=0, and go to RUN next cycle; start=0 SHALL stay in IDLE.
REQ-018 start SHALL be ignored in RUN and DONE, with no effect on state or registers.
REQ-019 Each RUN cycle SHALL update acc<=alu_res if mplr[0]=1, else hold acc; mcand<=mcand<<1 (bits shifted out discarded); mplr<=mplr>>1 (zero fill); cnt<=cnt+1.
REQ-020 cnt SHALL be 4 bits; the RUN cycle with cnt=15 SHALL be the last, then go to DONE; cnt SHALL NOT wrap in RUN.
REQ-021 The ADD result SHALL be truncated to 16 bits; carry ignored.
REQ-022 The product SHALL be the low 16 bits, correct for both unsigned and two's-complement operands.
REQ-023 product SHALL equal acc; it SHALL be held stable in DONE.
REQ-024 DONE with out_ready=1 SHALL go to IDLE next cycle; out_ready=0 SHALL hold DONE indefinitely.
REQ-025 Latency SHALL be: start accepted at cycle 0, RUN cycles 1..16, out_valid first high at cycle 17 (macro absent).
REQ-026 A back-to-back start SHALL be accepted no earlier than the first IDLE cycle after a DONE handshake.
REQ-027 alu_res SHALL be used only in RUN; its value in other states SHALL have no effect.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, acc=0, mcand=0, mplr=0, cnt=0.
REQ-029 After reset all outputs SHALL be 0: busy, out_valid, product, alu_own, alu_opcode, alu_funct, alu_rs, alu_rt.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation without producing out_valid; the first start after release SHALL start a fresh operation.

Configuration
REQ-031 Macro MUL_SEQ_EARLY_EXIT_EN defined: a RUN cycle SHALL also be the last when the next mplr (mplr>>1) is zero, so op_b=0 or op_b=1 gives one RUN cycle and out_valid at cycle 2.
REQ-032 MUL_SEQ_EARLY_EXIT_EN undefined: RUN SHALL always last exactly 16 cycles per REQ-025; the product SHALL be identical in both builds.

Verification
REQ-033 op_a=3, op_b=5, start at cycle 0, out_ready=1: out_valid at cycle 17, product=0x000F, alu_own high cycles 1..16 only.
REQ-034 op_a=0xFFFF, op_b=0xFFFF: product=0x0001; op_a=0x1234, op_b=0x0010: product=0x2340.
REQ-035 start pulsed with op_a=7, op_b=7 during RUN of 2*3: no effect; product=0x0006.
REQ-036 out_ready held low 5 cycles after out_valid: out_valid and product stay stable; out_ready=1 returns to IDLE next cycle with busy=0.
REQ-037 rst_n pulsed low at RUN cycle 8: all outputs 0 at once; the next start with 4*4 gives 0x0010 after full latency.
REQ-038 Macro defined: op_b=1 gives out_valid at cycle 2, product=op_a; op_b=0x8000 gives out_valid at cycle 17.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - shift-and-add 16x16 (low 16 bits) multiplier sequencer driving a shared ALU
// Optional MUL_SEQ_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module mul_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        alu_own,
    output logic [4:0]  alu_opcode,
    output logic [1:0]  alu_funct,
    output logic [15:0] alu_rs,
    output logic [15:0] alu_rt,
    input  logic [15:0] alu_res
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] ALU_OP_MUL_STEP = 5'b11011;
    localparam logic [1:0] ALU_FUNCT_ADD   = 2'b00;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_mplr;
    logic [3:0]  r_cnt;
    logic [15:0] w_acc_nxt;
    logic [15:0] w_mcand_nxt;
    logic [15:0] w_mplr_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_last;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign w_last = (r_cnt == 4'd15) || (r_mplr[15:1] == 15'd0);
`else
    assign w_last = (r_cnt == 4'd15);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_mcand_nxt = r_mcand;
        w_mplr_nxt  = r_mplr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_nxt   = 16'd0;
                    w_mcand_nxt = op_a;
                    w_mplr_nxt  = op_b;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // The shared ALU computes acc + shifted multiplicand; carry is dropped.
                if (r_mplr[0]) begin
                    w_acc_nxt = alu_res;
                end
                w_mcand_nxt = r_mcand << 1;
                w_mplr_nxt  = r_mplr >> 1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= 16'd0;
            r_mcand <= 16'd0;
            r_mplr  <= 16'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_mcand <= w_mcand_nxt;
            r_mplr  <= w_mplr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign busy       = (r_state == S_RUN) || (r_state == S_DONE);
    assign out_valid  = (r_state == S_DONE);
    assign product    = r_acc;
    assign alu_own    = (r_state == S_RUN);
    assign alu_opcode = alu_own ? ALU_OP_MUL_STEP : 5'd0;
    assign alu_funct  = ALU_FUNCT_ADD;
    assign alu_rs     = alu_own ? r_acc : 16'd0;
    assign alu_rt     = alu_own ? r_mcand : 16'd0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl against an arithmetic reference model
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        out_valid;
    logic [15:0] product;
    logic        alu_own;
    logic [4:0]  alu_opcode;
    logic [1:0]  alu_funct;
    logic [15:0] alu_rs;
    logic [15:0] alu_rt;
    logic [15:0] alu_res;
    logic [15:0] junk = 16'hA5A5;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Shared ALU: real ADD when granted, garbage otherwise.
    always @(negedge clk) junk = 16'($urandom);
    assign alu_res = alu_own ? 16'(alu_rs + alu_rt) : junk;

    mul_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .alu_own    (alu_own),
        .alu_opcode (alu_opcode),
        .alu_funct  (alu_funct),
        .alu_rs     (alu_rs),
        .alu_rt     (alu_rt),
        .alu_res    (alu_res)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_runs(input logic [15:0] b);
        int n;
        n = 16;
`ifdef MUL_SEQ_EARLY_EXIT_EN
        n = 1;
        for (int k = 1; k < 16; k++) begin
            if ((b >> k) != 16'd0) n = k + 1;
        end
`endif
        return n;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_valid"},  32'(out_valid), 32'd0);
        chk({tag, "_prod"},   32'(product), 32'd0);
        chk({tag, "_own"},    32'(alu_own), 32'd0);
        chk({tag, "_opc"},    32'(alu_opcode), 32'd0);
        chk({tag, "_funct"},  32'(alu_funct), 32'd0);
        chk({tag, "_rs"},     32'(alu_rs), 32'd0);
        chk({tag, "_rt"},     32'(alu_rt), 32'd0);
    endtask

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold, input bit pulse);
        logic [15:0] exp_p;
        int          n;
        int          cyc;
        exp_p = 16'((32'(a) * 32'(b)) & 32'hFFFF);
        n     = exp_runs(b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        cyc   = 1;
        while (!out_valid && cyc < 40) begin
            chk("run_own", 32'(alu_own), 32'd1);
            chk("run_opc", 32'(alu_opcode), 32'h1B);
            chk("run_busy", 32'(busy), 32'd1);
            if (pulse && cyc == 3) begin
                start = 1'b1;
                op_a  = 16'd7;
                op_b  = 16'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("latency", 32'(cyc), 32'(n + 1));
        chk("product", 32'(product), 32'(exp_p));
        chk("done_own", 32'(alu_own), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_funct", 32'(alu_funct), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_prod", 32'(product), 32'(exp_p));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("post_reset");

        do_op(16'd3, 16'd5, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
        do_op(16'h1234, 16'h0010, 0, 1'b0);
        do_op(16'd2, 16'd3, 0, 1'b1);
        do_op(16'hBEEF, 16'h00A7, 5, 1'b0);
        do_op(16'h5A5A, 16'd1, 1, 1'b0);
        do_op(16'h5A5A, 16'd0, 0, 1'b0);
        do_op(16'h4321, 16'h8000, 0, 1'b0);

        // Abort mid-run via reset, then a fresh operation.
        op_a  = 16'h0F0F;
        op_b  = 16'hF0F1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("mid_own", 32'(alu_own), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_abort_valid", 32'(out_valid), 32'd0);
        chk("after_abort_busy", 32'(busy), 32'd0);
        do_op(16'd4, 16'd4, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            do_op(16'($urandom), 16'($urandom >> (i % 16)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
